oscope_capture_reader: RTL and testbench
========================================

Name: oscope_capture_reader

Overview:
- Readout side of the oscilloscope capture path: after a capture has filled the sample FIFO, drains exactly DLEN samples.
- Streams them to a downstream consumer (UART framer / display engine) over a valid/ready byte stream, preceded by one header word carrying the latched trigger status.
- Sits between the sample FIFO read port and the host-link transmitter.

Parameters:
- DLEN, 1000, samples per capture frame to read; must be ≥ 2.
- DW, 8, sample/stream word width; must be ≥ 2.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  single-cycle request to begin readout of one frame
- abort  in  1  cancel readout in progress
- trigger_flag  in  1  capture trigger status, sampled on accepted start
- fifo_empty  in  1  sample FIFO empty
- fifo_rdata  in  DW  FIFO read data, valid the cycle after fifo_rd
- fifo_rd  out  1  FIFO read strobe, one word per pulse
- m_data  out  DW  stream data
- m_valid  out  1  stream data valid
- m_ready  in  1  consumer accepts m_data when m_valid && m_ready
- m_last  out  1  high with the final sample word of the frame
- busy  out  1  readout in progress (any state except IDLE)
- done  out  1  one-cycle pulse after the last word is accepted

Behaviour:
- Reset (async, any state): state=IDLE; m_valid, m_last, fifo_rd, done, busy = 0; m_data = 0; sample counter = 0; trig_latched = 0.
- States: IDLE, HDR, FETCH, LOAD, SEND.
- IDLE:
  - start=1 and abort=0 → HDR, with trig_latched ← trigger_flag and counter ← 0.
  - start while busy is ignored.
- HDR:
  - m_valid=1, m_data = {(DW-1){1'b1}, trig_latched}, m_last=0.
  - Handshake → FETCH.
  - m_data is held stable until accepted.
- FETCH:
  - fifo_empty=0 → fifo_rd=1 for one cycle, then → LOAD.
  - fifo_empty=1 → stay, fifo_rd=0; no timeout, abort is the escape.
- LOAD:
  - m_data ← fifo_rdata (registered), then → SEND.
  - fifo_rd=0.
- SEND:
  - m_valid=1, m_last = (counter == DLEN-1).
  - On handshake with m_last=1 → IDLE, and done=1 in the following cycle (registered pulse coincident with the first IDLE cycle).
  - On handshake without m_last → counter+1 and → FETCH.
- Data path and throughput:
  - m_valid and m_data are registered outputs.
  - m_data does not change while m_valid=1 and m_ready=0.
  - Throughput is at most one sample per 3 clocks; latency from start to header valid is 1 clock.
- Counter: width $clog2(DLEN); it never exceeds DLEN-1, so there is no wrap.
- abort:
  - Abort in any non-IDLE state → IDLE next cycle; m_valid, m_last and fifo_rd drop; no done pulse.
  - A FIFO word already requested (abort in LOAD) is discarded.
  - Abort in IDLE has no effect; abort wins over a simultaneous start.
- Frame size: exactly 1 header + DLEN samples per frame; fifo_rd pulses exactly DLEN times for an unaborted frame.
- Outputs: busy = (state != IDLE), combinational from the state register; done is a registered pulse.
- start on the same cycle as done (first IDLE cycle): accepted, and a new frame begins.

Test Plan:
- DLEN=4, DW=8, FIFO preloaded 11,22,33,44, trigger_flag=1 at start, m_ready=1 → stream FF,11,22,33,44; m_last only on 44; done 1 cycle after 44 accepted; 4 fifo_rd pulses.
- Same frame, trigger_flag=0 → header FE; samples unchanged.
- Backpressure: m_ready=0 for 5 cycles while header and then the second sample are valid → m_data held constant, no extra fifo_rd, no lost or duplicated word.
- FIFO underrun: fifo_empty=1 for 10 cycles before the 3rd sample → stays in FETCH with fifo_rd=0, busy=1; resumes correctly when the FIFO refills.
- Abort asserted in LOAD of the 2nd sample → m_valid=0 and busy=0 next cycle, no done; a new start then produces a fresh header.
- Async reset pulsed mid-SEND (not clock-aligned) → all outputs 0 immediately; a subsequent start behaves as a first frame. Also check that start asserted while busy is ignored (no second header).

Source files
------------

// File: rtl/oscope_capture_reader_if.sv
// Valid/ready byte stream from the capture reader to the host-link side.
// The master drives data/valid/last; the slave drives ready.
interface oscope_capture_reader_if #(
    parameter int DW = 8
);
    logic [DW-1:0] m_data;
    logic          m_valid;
    logic          m_ready;
    logic          m_last;

    modport master (
        output m_data,
        output m_valid,
        output m_last,
        input  m_ready
    );

    modport slave (
        input  m_data,
        input  m_valid,
        input  m_last,
        output m_ready
    );
endinterface

// File: rtl/oscope_capture_reader.sv
// Capture readout: after a capture, drains DLEN samples from the sample
// FIFO and streams a trigger-status header followed by the samples.
module oscope_capture_reader #(
    parameter int DLEN = 1000,
    parameter int DW   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_i,
    input  logic                     abort_i,
    input  logic                     trigger_flag_i,
    input  logic                     fifo_empty_i,
    input  logic [DW-1:0]            fifo_rdata_i,
    output logic                     fifo_rd_o,
    oscope_capture_reader_if.master  m,
    output logic                     busy_o,
    output logic                     done_o
);
    localparam int CW = (DLEN > 1) ? $clog2(DLEN) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(DLEN - 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_HDR   = 3'd1;
    localparam logic [2:0] S_FETCH = 3'd2;
    localparam logic [2:0] S_LOAD  = 3'd3;
    localparam logic [2:0] S_SEND  = 3'd4;

    logic [2:0]    state_q, state_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          trig_q,  trig_d;
    logic [DW-1:0] data_q,  data_d;
    logic          valid_q, valid_d;
    logic          last_q,  last_d;
    logic          done_q,  done_d;
    logic          hs;

    assign hs = valid_q && m.m_ready;

    // Next-state logic; abort from any active state returns straight to idle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        trig_d  = trig_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        done_d  = 1'b0;
        if (state_q != S_IDLE && abort_i) begin
            state_d = S_IDLE;
            valid_d = 1'b0;
            last_d  = 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start_i && !abort_i) begin
                        state_d = S_HDR;
                        trig_d  = trigger_flag_i;
                        cnt_d   = '0;
                        valid_d = 1'b1;
                        last_d  = 1'b0;
                        data_d  = {{(DW-1){1'b1}}, trigger_flag_i};
                    end
                end
                S_HDR: begin
                    data_d = {{(DW-1){1'b1}}, trig_q};
                    if (hs) begin
                        state_d = S_FETCH;
                        valid_d = 1'b0;
                    end
                end
                S_FETCH: begin
                    if (!fifo_empty_i) begin
                        state_d = S_LOAD;
                    end
                end
                S_LOAD: begin
                    data_d  = fifo_rdata_i;
                    valid_d = 1'b1;
                    last_d  = (cnt_q == LAST_IDX);
                    state_d = S_SEND;
                end
                S_SEND: begin
                    if (hs) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        if (last_q) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            cnt_d   = cnt_q + 1'b1;
                            state_d = S_FETCH;
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                end
            endcase
        end
    end

    // State and registered stream outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            trig_q  <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            trig_q  <= trig_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    // Read strobe is suppressed on abort so no FIFO word is lost silently
    assign fifo_rd_o = (state_q == S_FETCH) && !fifo_empty_i && !abort_i;
    assign busy_o    = (state_q != S_IDLE);
    assign done_o    = done_q;
    assign m.m_data  = data_q;
    assign m.m_valid = valid_q;
    assign m.m_last  = last_q;
endmodule

// File: tb/tb_oscope_capture_reader.sv
// Randomized scoreboard bench for oscope_capture_reader.
// Expected stream = header + FIFO contents in order; a monitor compares.
module tb_oscope_capture_reader;
    localparam int DLEN = 4;
    localparam int DW   = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          trig = 1'b0;
    logic          fifo_empty = 1'b1;
    logic [DW-1:0] fifo_rdata = '0;
    logic          fifo_rd;
    logic          busy;
    logic          done;

    oscope_capture_reader_if #(.DW(DW)) m_if ();

    always #5 clk = ~clk;

    oscope_capture_reader #(.DLEN(DLEN), .DW(DW)) dut (
        .clk            (clk),
        .rst            (rst),
        .start_i        (start),
        .abort_i        (abort),
        .trigger_flag_i (trig),
        .fifo_empty_i   (fifo_empty),
        .fifo_rdata_i   (fifo_rdata),
        .fifo_rd_o      (fifo_rd),
        .m              (m_if.master),
        .busy_o         (busy),
        .done_o         (done)
    );

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] fq[$];
    logic [DW:0]   expq[$];

    int   hs = 0;
    int   stall = 0;
    int   uf = 0;
    int   rd_cnt = 0;
    logic force_empty = 1'b0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Monitor: samples on the falling edge, away from the active edge
    logic          exp_done = 1'b0;
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data = '0;
    logic [DW:0]   e;

    always @(negedge clk) begin
        if (rst) begin
            exp_done   = 1'b0;
            prev_stall = 1'b0;
        end else begin
            if (exp_done || done) chk("done", {31'd0, done}, {31'd0, exp_done});
            exp_done = 1'b0;
            if (prev_stall) begin
                chk("hold_valid", {31'd0, m_if.m_valid}, 32'd1);
                chk("hold_data", {24'd0, m_if.m_data}, {24'd0, prev_data});
            end
            if (fifo_rd) begin
                chk("rd_while_empty", {31'd0, fifo_empty}, 32'd0);
                rd_cnt++;
            end
            if (m_if.m_valid && m_if.m_ready) begin
                if (expq.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_word: got %0h want none", {m_if.m_last, m_if.m_data});
                end else begin
                    e = expq.pop_front();
                    chk("word", {23'd0, m_if.m_last, m_if.m_data}, {23'd0, e});
                    if (e[DW]) begin
                        exp_done = 1'b1;
                        chk("rd_count", rd_cnt, DLEN);
                    end
                end
            end
            prev_stall = m_if.m_valid && !m_if.m_ready;
            prev_data  = m_if.m_data;
        end
    end

    // One clock; the FIFO model lives here so only the driver touches it
    task automatic step(output logic rd_now);
        logic took;
        fifo_empty = force_empty || (fq.size() == 0);
        #1;
        rd_now = fifo_rd;
        took = m_if.m_valid && m_if.m_ready;
        @(posedge clk);
        #1;
        if (rd_now && fq.size() > 0) fifo_rdata = fq.pop_front();
        if (took) begin
            hs++;
            stall = 0;
        end
    endtask

    task automatic do_reset();
        #2 rst = 1'b1;
        #1;
        chk("rst_valid", {31'd0, m_if.m_valid}, 32'd0);
        chk("rst_last", {31'd0, m_if.m_last}, 32'd0);
        chk("rst_data", {24'd0, m_if.m_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_rd", {31'd0, fifo_rd}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        #2 rst = 1'b0;
        expq.delete();
        fq.delete();
        @(posedge clk);
        #1;
    endtask

    // mode: 0 ready=1, 1 random ready, 2 stalls + start while busy,
    // 3 FIFO underrun, 4 abort in LOAD, 5 async reset mid-SEND
    task automatic run_frame(input logic tg, input int mode, input bit fixed);
        logic [DW-1:0] s;
        logic rd;
        logic in_load;
        logic ab;
        logic fin;
        int   cyc;
        expq.push_back({1'b0, {(DW-1){1'b1}}, tg});
        for (int i = 0; i < DLEN; i++) begin
            s = fixed ? DW'(17 * (i + 1)) : DW'($urandom);
            fq.push_back(s);
            expq.push_back({(i == DLEN - 1), s});
        end
        hs = 0; stall = 0; uf = 0; rd_cnt = 0;
        force_empty = 1'b0;
        trig = tg;
        start = 1'b1;
        m_if.m_ready = 1'b1;
        step(rd);
        start = 1'b0;
        trig = 1'($urandom_range(0, 1));
        chk("hdr_latency", {31'd0, m_if.m_valid}, 32'd1);
        chk("busy_hdr", {31'd0, busy}, 32'd1);
        fin = 1'b0;
        in_load = 1'b0;
        cyc = 0;
        while (!fin && cyc < 400) begin
            cyc++;
            if (mode == 2 && m_if.m_valid && (hs == 0 || hs == 2) && stall < 5) begin
                m_if.m_ready = 1'b0;
                stall++;
            end else if (mode == 5 && hs == 2) begin
                m_if.m_ready = 1'b0;
            end else begin
                m_if.m_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            end
            start = (mode == 2 && hs == 1);
            if (mode == 3 && hs == 3 && uf < 10) begin
                force_empty = 1'b1;
                uf++;
            end else begin
                force_empty = 1'b0;
            end
            ab = (mode == 4 && in_load);
            abort = ab;
            step(rd);
            abort = 1'b0;
            in_load = rd && (hs == 2);
            if (force_empty) begin
                chk("uf_busy", {31'd0, busy}, 32'd1);
                chk("uf_valid", {31'd0, m_if.m_valid}, 32'd0);
            end
            if (ab) begin
                chk("abort_valid", {31'd0, m_if.m_valid}, 32'd0);
                chk("abort_busy", {31'd0, busy}, 32'd0);
                expq.delete();
                fq.delete();
                fin = 1'b1;
            end else if (mode == 5 && hs == 2 && m_if.m_valid) begin
                do_reset();
                fin = 1'b1;
            end else if (done) begin
                fin = 1'b1;
            end
        end
        chk("frame_end", {31'd0, fin}, 32'd1);
        start = 1'b0;
        force_empty = 1'b0;
        m_if.m_ready = 1'b1;
    endtask

    task automatic idle(input int n);
        logic rd;
        for (int i = 0; i < n; i++) step(rd);
    endtask

    initial begin
        logic rd;
        m_if.m_ready = 1'b1;
        #1 rst = 1'b1;
        #10;
        chk("init_valid", {31'd0, m_if.m_valid}, 32'd0);
        chk("init_data", {24'd0, m_if.m_data}, 32'd0);
        chk("init_last", {31'd0, m_if.m_last}, 32'd0);
        chk("init_busy", {31'd0, busy}, 32'd0);
        chk("init_done", {31'd0, done}, 32'd0);
        chk("init_rd", {31'd0, fifo_rd}, 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        idle(2);

        abort = 1'b1;
        step(rd);
        chk("abort_idle", {31'd0, busy}, 32'd0);
        start = 1'b1;
        step(rd);
        chk("abort_beats_start", {31'd0, busy}, 32'd0);
        abort = 1'b0;
        start = 1'b0;
        idle(1);

        run_frame(1'b1, 0, 1'b1);
        run_frame(1'b0, 0, 1'b1);
        idle(3);
        run_frame(1'b1, 2, 1'b0);
        run_frame(1'b0, 3, 1'b0);
        run_frame(1'b1, 4, 1'b0);
        idle(2);
        chk("no_done_after_abort", {31'd0, done}, 32'd0);
        run_frame(1'b0, 0, 1'b0);
        run_frame(1'b1, 5, 1'b0);
        run_frame(1'b1, 0, 1'b1);
        for (int k = 0; k < 8; k++) begin
            run_frame(1'($urandom_range(0, 1)), 1, 1'b0);
            if (k[0]) idle(1);
        end
        idle(4);
        chk("exp_drained", expq.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
